// File: rtl/qea_host_sequencer.sv
// Host-side job sequencer for one QEA instance: loads context words and initial
// state rows, starts the engine, times the run, then streams the final state out.
module qea_host_sequencer #(
  parameter int unsigned PE_NUM_WIDTH            = 2,
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned RD_LATENCY              = 1,
  parameter int unsigned CYC_WIDTH               = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ctx_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
  input  logic                                 i_st_valid,
  output logic                                 o_st_ready,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_word,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_word,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_start,
  input  logic                                 i_complete,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [CYC_WIDTH-1:0]                 o_exec_cycles
);

  localparam int unsigned RCW = STATE_ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, LOAD_ST, START, WAIT, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
  } state_t;

  state_t                             state;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_idx;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_last;
  logic [STATE_ADDR_WIDTH-1:0]        row;
  logic [STATE_ADDR_WIDTH-1:0]        row_last;
  logic [CYC_WIDTH-1:0]               cyc_cnt;
  logic [1:0]                         lat_cnt;
  logic [MAX_QBIT_WIDTH-1:0]          row_shift;
  logic [RCW-1:0]                     row_count;
  logic                               job_ok;

  always_comb begin
    row_shift = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    row_count = RCW'(1) << row_shift;
    job_ok    = (i_ctx_num != '0)
             && (i_ctx_num <= {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}})
             && (i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
             && (row_shift <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ctx_idx       <= '0;
      ctx_last      <= '0;
      row           <= '0;
      row_last      <= '0;
      cyc_cnt       <= '0;
      lat_cnt       <= '0;
      o_ctx_ready   <= 1'b0;
      o_st_ready    <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_word     <= '0;
      o_ctx_en      <= 1'b0;
      o_ctx_wea     <= 1'b0;
      o_ctx_addr    <= '0;
      o_ctx_data    <= '0;
      o_state_ena   <= 1'b0;
      o_state_wea   <= 1'b0;
      o_state_addra <= '0;
      o_state_dina  <= '0;
      o_start       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_exec_cycles <= '0;
    end else begin
      o_ctx_en    <= 1'b0;
      o_ctx_wea   <= 1'b0;
      o_state_ena <= 1'b0;
      o_state_wea <= 1'b0;
      o_start     <= 1'b0;
      o_done      <= 1'b0;
      unique case (state)
        IDLE: if (i_run) begin
          ctx_last <= GATE_CONTEXT_ADDR_WIDTH'(i_ctx_num - 1'b1);
          row_last <= STATE_ADDR_WIDTH'(row_count - 1'b1);
          ctx_idx  <= '0;
          o_busy   <= 1'b1;
          if (job_ok) begin
            o_err       <= 1'b0;
            o_ctx_ready <= 1'b1;
            state       <= LOAD_CTX;
          end else begin
            o_err  <= 1'b1;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        LOAD_CTX: if (i_ctx_valid) begin
          o_ctx_en   <= 1'b1;
          o_ctx_wea  <= 1'b1;
          o_ctx_addr <= ctx_idx;
          o_ctx_data <= i_ctx_word;
          ctx_idx    <= ctx_idx + 1'b1;
          if (ctx_idx == ctx_last) begin
            o_ctx_ready <= 1'b0;
            o_st_ready  <= 1'b1;
            row         <= '0;
            state       <= LOAD_ST;
          end
        end
        LOAD_ST: if (i_st_valid) begin
          o_state_ena   <= 1'b1;
          o_state_wea   <= 1'b1;
          o_state_addra <= row;
          o_state_dina  <= i_st_word;
          row           <= row + 1'b1;
          if (row == row_last) begin
            o_st_ready <= 1'b0;
            o_start    <= 1'b1;
            cyc_cnt    <= CYC_WIDTH'(1);
            state      <= START;
          end
        end
        // The START cycle itself counts as cycle 1 of the run.
        START: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (i_complete) begin
            o_exec_cycles <= cyc_cnt;
            row           <= '0;
            o_state_ena   <= 1'b1;
            o_state_addra <= '0;
            state         <= RD_ISSUE;
          end else if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        RD_ISSUE: begin
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        // The RAM registers the request at the end of RD_ISSUE, so dout is
        // valid RD_LATENCY cycles after that edge.
        RD_WAIT: begin
          if (lat_cnt == 2'(RD_LATENCY - 1)) begin
            o_rd_word  <= i_state_dout;
            o_rd_valid <= 1'b1;
            state      <= RD_HOLD;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RD_HOLD: if (i_rd_ready) begin
          o_rd_valid <= 1'b0;
          if (row == row_last) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            row           <= row + 1'b1;
            o_state_ena   <= 1'b1;
            o_state_addra <= row + 1'b1;
            state         <= RD_ISSUE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
